coffee_recipe_sequencer: RTL and testbench

//  Parametrised, timed successor of the single-cycle drink selector: latches one of NUM_RECIPES

---
 rtl/coffee_pkg.sv | 53 +++++
 rtl/coffee_req_prio.sv | 21 ++
 rtl/coffee_recipe_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_coffee_recipe_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee recipe sequencer: FSM state
// encoding, recipe flag bit positions, default recipe table and the
// stage -> actuator mapping.
package coffee_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CUP,
    S_POUR,
    S_SUGAR,
    S_STIR,
    S_DONE
  } state_e;

  // Bit positions inside one 5-bit recipe entry {stir,sugar,coffee,water,milk}
  localparam int FLAG_MILK   = 0;
  localparam int FLAG_WATER  = 1;
  localparam int FLAG_COFFEE = 2;
  localparam int FLAG_SUGAR  = 3;
  localparam int FLAG_STIR   = 4;
  localparam int FLAG_W      = 5;

  // r0..r5 = mwis, mwos, ewis, ewos, cwis, cwos
  localparam logic [29:0] DEFAULT_RECIPE_TBL = 30'h2BDB7839;

  typedef struct packed {
    logic pump;
    logic milk;
    logic water;
    logic coffee;
    logic sugar;
    logic stir;
  } act_t;

  // Actuator pattern for a given stage and latched recipe flags.
  function automatic act_t stage_outs(state_e s, logic [FLAG_W-1:0] f);
    act_t a;
    a = '0;
    case (s)
      S_POUR: begin
        a.pump   = 1'b1;
        a.milk   = f[FLAG_MILK];
        a.water  = f[FLAG_WATER];
        a.coffee = f[FLAG_COFFEE];
      end
      S_SUGAR: a.sugar = 1'b1;
      S_STIR:  a.stir  = 1'b1;
      default: ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/coffee_req_prio.sv
// Lowest-index-wins priority encoder for the drink request vector.
module coffee_req_prio #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_valid = |i_req;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) o_idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/coffee_recipe_sequencer.sv
// Timed drink sequencer: accepts one request, waits for a cup, then runs
// POUR -> SUGAR -> STIR stages from a recipe table and holds DONE until the
// cup is removed. All outputs are registered.
// Optional feature: define COFFEE_SERVE_CNT_EN to add the saturating
// serve_cnt output counting completed drinks.
module coffee_recipe_sequencer
  import coffee_pkg::*;
#(
  parameter int                             NUM_RECIPES = 6,
  parameter logic [NUM_RECIPES*FLAG_W-1:0]  RECIPE_TBL  = DEFAULT_RECIPE_TBL,
  parameter int                             TMR_W       = 8,
  parameter logic [TMR_W-1:0]               POUR_CYC    = 8'd40,
  parameter logic [TMR_W-1:0]               SUGAR_CYC   = 8'd10,
  parameter logic [TMR_W-1:0]               STIR_CYC    = 8'd20,
  parameter logic [TMR_W-1:0]               CUP_TO      = 8'd200,
  localparam int                            ID_W        = $clog2(NUM_RECIPES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_RECIPES-1:0] req,
  input  logic                   cup_present,
  output logic                   ack,
  output logic                   busy,
  output logic [ID_W-1:0]        recipe_id,
  output logic                   pump,
  output logic                   milk,
  output logic                   water,
  output logic                   coffee,
  output logic                   sugar,
  output logic                   stir,
  output logic                   done,
  output logic                   err
`ifdef COFFEE_SERVE_CNT_EN
  ,
  output logic [15:0]            serve_cnt
`endif
);

  logic              w_req_valid;
  logic [ID_W-1:0]   w_req_idx;
  logic [FLAG_W-1:0] w_req_flags;

  state_e            w_next;
  logic [TMR_W-1:0]  w_tmr;
  logic              w_ack;
  logic              w_err;

  state_e            r_state;
  logic [TMR_W-1:0]  r_tmr;
  logic [ID_W-1:0]   r_id;
  logic [FLAG_W-1:0] r_flags;
  logic              r_ack;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  act_t              r_act;

  coffee_req_prio #(
    .N     (NUM_RECIPES),
    .IDX_W (ID_W)
  ) u_prio (
    .i_req   (req),
    .o_valid (w_req_valid),
    .o_idx   (w_req_idx)
  );

  // Look up the 5 recipe flags for the winning request index.
  always_comb begin
    w_req_flags = '0;
    for (int k = 0; k < NUM_RECIPES; k++) begin
      if (w_req_idx == ID_W'(k)) w_req_flags = RECIPE_TBL[k*FLAG_W +: FLAG_W];
    end
  end

  // Next state, stage timer and pulse decisions; abort is checked before stage end.
  always_comb begin
    w_next = r_state;
    w_tmr  = (r_tmr != '0) ? r_tmr - 1'b1 : r_tmr;
    w_ack  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmr = '0;
        if (start && w_req_valid) begin
          w_next = S_WAIT_CUP;
          w_ack  = 1'b1;
          w_tmr  = CUP_TO - 1'b1;
        end
      end
      S_WAIT_CUP: begin
        if (!start) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
          w_tmr  = '0;
        end else if (cup_present) begin
          w_next = S_POUR;
          w_tmr  = POUR_CYC - 1'b1;
        end else if (r_tmr == '0) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end
      end
      S_POUR, S_SUGAR, S_STIR: begin
        if (!start || !cup_present) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
          w_tmr  = '0;
        end else if (r_tmr == '0) begin
          if (r_state == S_POUR && r_flags[FLAG_SUGAR]) begin
            w_next = S_SUGAR;
            w_tmr  = SUGAR_CYC - 1'b1;
          end else if (r_state != S_STIR && r_flags[FLAG_STIR]) begin
            w_next = S_STIR;
            w_tmr  = STIR_CYC - 1'b1;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_tmr = '0;
        if (!start || !cup_present) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
        w_tmr  = '0;
      end
    endcase
  end

  // FSM register with outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_id    <= '0;
      r_flags <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_act   <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so all registers update from pre-edge values.
      r_state <= w_next;
      r_tmr   <= w_tmr;
      if (w_ack) begin
        r_id    <= w_req_idx;
        r_flags <= w_req_flags;
      end
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_act   <= stage_outs(w_next, r_flags);
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign recipe_id = r_id;
  assign done      = r_done;
  assign err       = r_err;
  assign pump      = r_act.pump;
  assign milk      = r_act.milk;
  assign water     = r_act.water;
  assign coffee    = r_act.coffee;
  assign sugar     = r_act.sugar;
  assign stir      = r_act.stir;

`ifdef COFFEE_SERVE_CNT_EN
  logic [15:0] r_serve_cnt;

  // Count entries into DONE; aborted drinks never reach DONE. Saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_serve_cnt <= '0;
    end else if (w_next == S_DONE && r_state != S_DONE && r_serve_cnt != 16'hFFFF) begin
      r_serve_cnt <= r_serve_cnt + 1'b1;
    end
  end

  assign serve_cnt = r_serve_cnt;
`endif

endmodule

// File: tb/tb_coffee_recipe_sequencer.sv
// Directed bench for coffee_recipe_sequencer. Inputs change and outputs are
// sampled on the falling clock edge. Output vector order:
// {ack,busy,done,err,pump,milk,water,coffee,sugar,stir}.
module tb_coffee_recipe_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] req;
  logic       cup_present;
  logic       ack, busy, pump, milk, water, coffee, sugar, stir, done, err;
  logic [2:0] recipe_id;
`ifdef COFFEE_SERVE_CNT_EN
  logic [15:0] serve_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] V_IDLE   = 10'b0000_000000;
  localparam logic [9:0] V_ACK    = 10'b1100_000000;
  localparam logic [9:0] V_WAIT   = 10'b0100_000000;
  localparam logic [9:0] V_ERR    = 10'b0001_000000;
  localparam logic [9:0] V_DONE   = 10'b0110_000000;
  localparam logic [9:0] V_SUGAR  = 10'b0100_000010;
  localparam logic [9:0] V_STIR   = 10'b0100_000001;
  localparam logic [9:0] V_POUR_E = 10'b0100_101100; // pump,water,coffee
  localparam logic [9:0] V_POUR_M = 10'b0100_110000; // pump,milk
  localparam logic [9:0] V_POUR_C = 10'b0100_110100; // pump,milk,coffee

  coffee_recipe_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .req         (req),
    .cup_present (cup_present),
    .ack         (ack),
    .busy        (busy),
    .recipe_id   (recipe_id),
    .pump        (pump),
    .milk        (milk),
    .water       (water),
    .coffee      (coffee),
    .sugar       (sugar),
    .stir        (stir),
    .done        (done),
    .err         (err)
`ifdef COFFEE_SERVE_CNT_EN
    ,
    .serve_cnt   (serve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {ack, busy, done, err, pump, milk, water, coffee, sugar, stir};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    req         = '0;
    cup_present = 1'b0;
    #7;
    check("reset_outs", outs(), V_IDLE);
    check("reset_id", recipe_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("idle_no_start", outs(), V_IDLE);

    // 1: ewis -- pour 40, sugar 10, stir 20, done until cup removed
    start = 1'b1; cup_present = 1'b1; req = 6'b000100;
    step(1);
    check("t1_ack", outs(), V_ACK);
    check("t1_id", recipe_id, 2);
    req = '0;
    step(1);  check("t1_pour_first", outs(), V_POUR_E);
    step(39); check("t1_pour_last", outs(), V_POUR_E);
    step(1);  check("t1_sugar_first", outs(), V_SUGAR);
    step(9);  check("t1_sugar_last", outs(), V_SUGAR);
    step(1);  check("t1_stir_first", outs(), V_STIR);
    step(19); check("t1_stir_last", outs(), V_STIR);
    step(1);  check("t1_done", outs(), V_DONE);
    step(3);  check("t1_done_held", outs(), V_DONE);
    cup_present = 1'b0;
    step(1);  check("t1_cup_removed", outs(), V_IDLE);

    // 2: mwos -- pour only with milk, then DONE; start low in DONE gives no err
    cup_present = 1'b1; req = 6'b000010;
    step(1);  check("t2_ack", outs(), V_ACK);
    check("t2_id", recipe_id, 1);
    req = '0;
    step(1);  check("t2_pour_first", outs(), V_POUR_M);
    step(39); check("t2_pour_last", outs(), V_POUR_M);
    step(1);  check("t2_done", outs(), V_DONE);
    start = 1'b0;
    step(1);  check("t2_start_low_done", outs(), V_IDLE);
    start = 1'b1;

    // 3: req 110000 -> cwis (id 4); req change mid-run ignored
    req = 6'b110000;
    step(1);  check("t3_ack", outs(), V_ACK);
    check("t3_id", recipe_id, 4);
    req = 6'b000001;
    step(1);  check("t3_pour_first", outs(), V_POUR_C);
    step(40); check("t3_sugar", outs(), V_SUGAR);
    step(10); check("t3_stir", outs(), V_STIR);
    step(20); check("t3_done", outs(), V_DONE);
    check("t3_id_kept", recipe_id, 4);
    req = '0;
    cup_present = 1'b0;
    step(1);  check("t3_cup_removed", outs(), V_IDLE);

    // 4: no cup -> err pulse 200 cycles after accept
    req = 6'b000001;
    step(1);  check("t4_ack", outs(), V_ACK);
    check("t4_id", recipe_id, 0);
    req = '0;
    step(199); check("t4_still_waiting", outs(), V_WAIT);
    step(1);   check("t4_timeout_err", outs(), V_ERR);
    step(1);   check("t4_err_one_cycle", outs(), V_IDLE);

    // 5a: cup removed at pour cycle 15
    cup_present = 1'b1; req = 6'b000100;
    step(1);  check("t5a_ack", outs(), V_ACK);
    req = '0;
    step(1);  check("t5a_pour", outs(), V_POUR_E);
    step(14); check("t5a_pour_c15", outs(), V_POUR_E);
    cup_present = 1'b0;
    step(1);  check("t5a_abort", outs(), V_ERR);
    step(1);  check("t5a_idle", outs(), V_IDLE);

    // 5b: start low during sugar
    cup_present = 1'b1; req = 6'b000100;
    step(1);  check("t5b_ack", outs(), V_ACK);
    req = '0;
    step(41); check("t5b_sugar", outs(), V_SUGAR);
    start = 1'b0;
    step(1);  check("t5b_abort", outs(), V_ERR);
    start = 1'b1;
    step(1);  check("t5b_idle", outs(), V_IDLE);

`ifdef COFFEE_SERVE_CNT_EN
    check("serve_cnt", serve_cnt, 3);
`endif

    // 6: async reset mid-stir (mwis: pour 40, sugar 10, then stir)
    req = 6'b000001;
    step(1);  check("t6_ack", outs(), V_ACK);
    req = '0;
    step(51); check("t6_stir", outs(), V_STIR);
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_outs", outs(), V_IDLE);
    check("t6_reset_id", recipe_id, 0);
`ifdef COFFEE_SERVE_CNT_EN
    check("t6_reset_cnt", serve_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
